fc_dense_layer: RTL
===================

// Module: fc_dense_layer
// PURPOSE
//  Fully-connected stage after conv/ReLU/max-pool/flatten. Reads the flattened
//  20-bit Q4.16 feature vector from layer-2 memory and computes N_OUT neurons:
//  sum(feature[i]*weight[n][i]) + bias[n], rounded and saturated to Q4.16.
//  Writes each neuron result to a result memory. Started by the flatten stage's done.
// PARAMETERS
//  N_IN    2048  flattened feature count (layer-2 memory depth)
//  N_OUT   10    neuron count
//  DATA_W  20    data width, signed Q4.16
//  FRAC_W  16    fractional bits
//  ACC_W   52    accumulator width; must be >= 2*DATA_W + clog2(N_IN)
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-high
//  start     in   1       one-cycle pulse; sampled only in IDLE
//  busy      out  1       high from the cycle after an accepted start until DONE
//  done      out  1       one-cycle pulse after the last neuron write
//  fm_rd     out  1       feature memory read enable
//  fm_addr   out  12      feature address, 0..N_IN-1
//  fm_rdata  in   20      feature data, valid 1 cycle after fm_rd
//  w_rd      out  1       weight ROM read enable
//  w_addr    out  WA      n*N_IN+i, WA=clog2(N_IN*N_OUT)
//  w_rdata   in   20      weight data, valid 1 cycle after w_rd
//  b_addr    out  OA      bias index n, OA=clog2(N_OUT)
//  b_rdata   in   20      bias data, valid 1 cycle after b_addr changes
//  o_wr      out  1       result write strobe, one cycle
//  o_addr    out  OA      result index n
//  o_wdata   out  20      result, Q4.16
// BEHAVIOUR
//  - Reset: every output 0; FSM in IDLE; counters and accumulator cleared.
//    Reset mid-run aborts immediately with no partial write. A new start is
//    required afterwards.
//  - FSM states: IDLE -> BIAS -> MAC -> DRAIN -> ROUND -> WRITE -> (BIAS|FIN) -> IDLE.
//  - IDLE: on start, go to BIAS. The next-cycle busy=1 and n=0.
//    start while busy is ignored.
//  - BIAS (1 cyc): b_addr=n. The accumulator loads sign-extended bias<<FRAC_W
//    on the following cycle.
//  - MAC (N_IN cyc): fm_rd=w_rd=1, fm_addr=i, w_addr=n*N_IN+i, i=0..N_IN-1.
//    Pipeline: read data at +1, registered 40-bit signed product at +2,
//    accumulate at +3.
//  - DRAIN (2 cyc): reads off; pipeline flushes the last two products.
//  - ROUND (1 cyc): r = (acc + 2^(FRAC_W-1)) >>> FRAC_W, round half up.
//    Saturate r to [0x80000, 0x7FFFF].
//  - WRITE (1 cyc): o_wr=1, o_addr=n, o_wdata=r.
//    If n==N_OUT-1, go to FIN; else n++ and go to BIAS.
//  - FIN (1 cyc): done=1, busy=0 in the same cycle; then IDLE.
//  - Per-neuron latency is N_IN+5 cycles. Total from start is N_OUT*(N_IN+5)+2 cycles.
//  - fm_rd/w_rd are never high outside MAC. o_wr is never high outside WRITE.
//  - Wrap-around: i rolls 0..N_IN-1 and resets per neuron. No address exceeds range.
// CONFIGURATION
//  FC_RELU_EN defined: ROUND clamps negative results to 0x00000 after saturation.
//  FC_RELU_EN undefined: signed saturated result written unchanged (logits mode).
// STRUCTURE
//  fc_pkg: DATA_W/FRAC_W/ACC_W constants, SAT_MAX=20'h7FFFF, SAT_MIN=20'h80000,
//    fc_state_t enum (IDLE,BIAS,MAC,DRAIN,ROUND,WRITE,FIN).
//  Sub-module fc_mac_pipe: product register + accumulator with load_bias,
//    mac_en and clear inputs. Top holds FSM, counters, address generation,
//    round/saturate and write.
// TESTING (N_IN=4, N_OUT=2 unless noted)
//  1 features=0x10000, weights=0x08000, bias=0 -> o_wdata=0x20000 for n=0,1; done once.
//  2 features=0x70000, weights=0x70000, bias=0x70000 -> 0x7FFFF (positive saturation).
//  3 weights=0, bias[0]=0xF0000 -> with FC_RELU_EN: 0x00000; without: 0xF0000.
//  4 feature[0]=0x00001, weight=0x08000, rest 0 -> 0x00001 (half LSB rounds up).
//  5 reset asserted mid-MAC of n=1 -> all outputs 0 at once, no o_wr.
//    Restart gives case-1 results.
//  6 start pulsed while busy -> ignored. Exactly N_OUT writes in total;
//    default params: done at N_OUT*(N_IN+5)+2 = 20532 cycles.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared constants and state type for the fully-connected dense layer.
// Build option: define FC_RELU_EN to clamp negative neuron results to zero.
package fc_pkg;

  localparam int DATA_W = 20;
  localparam int FRAC_W = 16;
  localparam int ACC_W  = 52;
  localparam int PROD_W = 2 * DATA_W;
  localparam int FA_W   = 12;

  localparam logic [DATA_W-1:0] SAT_MAX = 20'h7FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 20'h80000;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    ROUND,
    WRITE,
    FIN
  } fc_state_t;

endpackage

// File: rtl/fc_mac_pipe.sv
// Multiply-accumulate datapath: one registered signed product stage followed
// by the accumulator. The accumulator is seeded with the bias (scaled to the
// product's fixed-point position) and then sums every valid product.
module fc_mac_pipe
  import fc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_bias,
  input  logic [DATA_W-1:0] bias,
  input  logic              mac_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod_reg;
  logic                     prod_v_reg;
  logic        [ACC_W-1:0]  acc_reg;
  logic        [ACC_W-1:0]  bias_ext;
  logic        [ACC_W-1:0]  prod_ext;

  // Bias is Q4.16; products are Q8.32, so shift the bias up by FRAC_W.
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
  assign prod_ext = {{(ACC_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
  assign acc      = acc_reg;

  // Product register and accumulator; bias load takes priority over accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_reg   <= '0;
      prod_v_reg <= 1'b0;
      acc_reg    <= '0;
    end else if (clear) begin
      prod_reg   <= '0;
      prod_v_reg <= 1'b0;
      acc_reg    <= '0;
    end else begin
      prod_v_reg <= mac_en;
      if (mac_en)
        prod_reg <= $signed(a) * $signed(b);
      if (load_bias)
        acc_reg <= bias_ext;
      else if (prod_v_reg)
        acc_reg <= acc_reg + prod_ext;
    end
  end

endmodule

// File: rtl/fc_dense_layer.sv
// Fully-connected layer: for each neuron n, seeds the accumulator with
// bias[n], streams N_IN feature/weight pairs through the MAC pipe, then
// rounds (half up) and saturates to Q4.16 and writes the result.
// Build option: define FC_RELU_EN to clamp negative results to zero;
// otherwise signed logits are written unchanged.
module fc_dense_layer
  import fc_pkg::*;
#(
  parameter int N_IN  = 2048,
  parameter int N_OUT = 10,
  parameter int WA    = $clog2(N_IN * N_OUT),
  parameter int OA    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fm_rd,
  output logic [FA_W-1:0]   fm_addr,
  input  logic [DATA_W-1:0] fm_rdata,
  output logic              w_rd,
  output logic [WA-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [OA-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              o_wr,
  output logic [OA-1:0]     o_addr,
  output logic [DATA_W-1:0] o_wdata
);

  localparam int R_W = ACC_W - FRAC_W;
  localparam logic [FA_W-1:0]  I_LAST = FA_W'(N_IN - 1);
  localparam logic [OA-1:0]    N_LAST = OA'(N_OUT - 1);
  localparam logic [ACC_W-1:0] HALF   = ACC_W'(64'd1 << (FRAC_W - 1));

  fc_state_t         state_reg, state_next;
  logic [OA-1:0]     n_reg;
  logic [FA_W-1:0]   i_reg;
  logic [WA-1:0]     w_cnt_reg;
  logic              drain_reg;
  logic              bias_ld_reg;
  logic              mac_v_reg;
  logic [DATA_W-1:0] result_reg;

  logic [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0] rsum;
  logic signed [R_W-1:0]   rshift;
  logic [DATA_W-1:0]       rounded;

  fc_mac_pipe u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_reg == IDLE),
    .load_bias (bias_ld_reg),
    .bias      (b_rdata),
    .mac_en    (mac_v_reg),
    .a         (fm_rdata),
    .b         (w_rdata),
    .acc       (acc)
  );

  // Round half up, then saturate the integer part to the Q4.16 range.
  always_comb begin
    rsum    = $signed(acc) + $signed(HALF);
    rshift  = R_W'(rsum >>> FRAC_W);
    rounded = rshift[DATA_W-1:0];
    if (!((rshift[R_W-1:DATA_W-1] == '0) || (rshift[R_W-1:DATA_W-1] == '1)))
      rounded = rshift[R_W-1] ? SAT_MIN : SAT_MAX;
`ifdef FC_RELU_EN
    if (rounded[DATA_W-1])
      rounded = '0;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic and all outputs decoded from the current state.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    fm_rd      = 1'b0;
    fm_addr    = '0;
    w_rd       = 1'b0;
    w_addr     = '0;
    b_addr     = n_reg;
    o_wr       = 1'b0;
    o_addr     = '0;
    o_wdata    = '0;
    case (state_reg)
      IDLE: begin
        if (start)
          state_next = BIAS;
      end
      BIAS: begin
        busy       = 1'b1;
        state_next = MAC;
      end
      MAC: begin
        busy    = 1'b1;
        fm_rd   = 1'b1;
        w_rd    = 1'b1;
        fm_addr = i_reg;
        w_addr  = w_cnt_reg;
        if (i_reg == I_LAST)
          state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_reg)
          state_next = ROUND;
      end
      ROUND: begin
        busy       = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        o_wr       = 1'b1;
        o_addr     = n_reg;
        o_wdata    = result_reg;
        state_next = (n_reg == N_LAST) ? FIN : BIAS;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Neuron/feature counters, weight address, pipeline valid flags, result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_reg       <= '0;
      i_reg       <= '0;
      w_cnt_reg   <= '0;
      drain_reg   <= 1'b0;
      bias_ld_reg <= 1'b0;
      mac_v_reg   <= 1'b0;
      result_reg  <= '0;
    end else begin
      bias_ld_reg <= (state_reg == BIAS);
      mac_v_reg   <= (state_reg == MAC);
      case (state_reg)
        IDLE: begin
          if (start) begin
            n_reg     <= '0;
            i_reg     <= '0;
            w_cnt_reg <= '0;
          end
        end
        BIAS: begin
          i_reg     <= '0;
          drain_reg <= 1'b0;
        end
        MAC: begin
          i_reg     <= (i_reg == I_LAST) ? '0 : i_reg + FA_W'(1);
          w_cnt_reg <= w_cnt_reg + WA'(1);
        end
        DRAIN: drain_reg <= ~drain_reg;
        ROUND: result_reg <= rounded;
        WRITE: begin
          if (n_reg != N_LAST)
            n_reg <= n_reg + OA'(1);
        end
        FIN: n_reg <= '0;
        default: ;
      endcase
    end
  end

endmodule
